// File: rtl/neuron_sequencer.sv
// +----------------------------------------------------------------------------+
// | neuron_sequencer: clear/bias/MAC/done control sequencer for one neuron.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module neuron_sequencer #(
  parameter int N_INPUTS   = 8,
  parameter int ADDR_WIDTH = $clog2(N_INPUTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  lu_clear_o,
  output logic                  lu_add_bias_o,
  output logic                  lu_sum_en_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_BIAS  = 3'd2,
    S_MAC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(N_INPUTS - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_TWO  = ADDR_WIDTH'(2);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ready_q, ready_d;
  logic                    clear_q, clear_d;
  logic                    bias_q, bias_d;
  logic                    mac_q, mac_d;
  logic                    valid_q, valid_d;

  // Output flags are computed for the next state so they come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    ready_d = 1'b0;
    clear_d = 1'b0;
    bias_d  = 1'b0;
    mac_d   = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_BIAS;
        bias_d  = 1'b1;
      end
      S_BIAS: begin
        state_d = S_MAC;
        mac_d   = 1'b1;
        addr_d  = cnt_q + C_ONE;
      end
      S_MAC: begin
        if (data_valid_i) begin
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + C_ONE;
            mac_d  = 1'b1;
            addr_d = cnt_q + C_TWO;
          end
        end else begin
          mac_d  = 1'b1;
          addr_d = addr_q;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      clear_q <= 1'b0;
      bias_q  <= 1'b0;
      mac_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      clear_q <= clear_d;
      bias_q  <= bias_d;
      mac_q   <= mac_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o       = ready_q;
  assign data_ready_o  = mac_q;
  assign mem_addr_o    = addr_q;
  assign lu_add_bias_o = bias_q;
  assign valid_o       = valid_q;
  // Reset forces a clear and suppresses accumulation so the two never overlap.
  assign lu_clear_o    = clear_q | reset_i;
  assign lu_sum_en_o   = (bias_q | (mac_q & data_valid_i)) & ~reset_i;

endmodule

`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_neuron_sequencer: directed checks of neuron_sequencer (N=4 and N=1).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_neuron_sequencer;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0, data_valid_i = 1'b0, ready_i = 1'b1;
  logic       ready_o, data_ready_o, lu_clear_o, lu_add_bias_o, lu_sum_en_o, valid_o;
  logic [2:0] mem_addr_o;

  logic       start1_i = 1'b0, data_valid1_i = 1'b1, ready1_i = 1'b1;
  logic       ready1_o, data_ready1_o, lu_clear1_o, lu_add_bias1_o, lu_sum_en1_o, valid1_o;
  logic [0:0] mem_addr1_o;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [15:0] acc;

  always #5 clk = ~clk;

  neuron_sequencer #(.N_INPUTS(4)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .ready_o(ready_o),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .mem_addr_o(mem_addr_o),
    .lu_clear_o(lu_clear_o), .lu_add_bias_o(lu_add_bias_o), .lu_sum_en_o(lu_sum_en_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  neuron_sequencer #(.N_INPUTS(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start1_i), .ready_o(ready1_o),
    .data_valid_i(data_valid1_i), .data_ready_o(data_ready1_o), .mem_addr_o(mem_addr1_o),
    .lu_clear_o(lu_clear1_o), .lu_add_bias_o(lu_add_bias1_o), .lu_sum_en_o(lu_sum_en1_o),
    .valid_o(valid1_o), .ready_i(ready1_i)
  );

  // Packed view: {ready, clear, bias, sum_en, data_ready, valid, addr}
  wire [8:0] obs  = {ready_o, lu_clear_o, lu_add_bias_o, lu_sum_en_o, data_ready_o, valid_o, mem_addr_o};
  wire [6:0] obs1 = {ready1_o, lu_clear1_o, lu_add_bias1_o, lu_sum_en1_o, data_ready1_o, valid1_o, mem_addr1_o};

  // Q8.8 datapath model: bias 1.0 at address 0, weights 0.5, inputs 2.0.
  function automatic logic [15:0] term(input logic [2:0] a, input logic add_bias);
    logic [31:0] w;
    w = (a == 3'd0) ? 32'h0100 : 32'h0080;
    if (add_bias) return w[15:0];
    return 16'((w * 32'h0200) >> 8);
  endfunction

  always @(posedge clk) begin
    if (lu_clear_o) acc <= 16'h0000;
    else if (lu_sum_en_o) acc <= acc + term(mem_addr_o, lu_add_bias_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic st, input logic dv,
                     input logic rdy, input logic [8:0] exp);
    reset_i = rst; start_i = st; data_valid_i = dv; ready_i = rdy;
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(exp));
    @(posedge clk); #1;
    start_i = 1'b0; reset_i = 1'b0;
  endtask

  logic [8:0] exp_stream [0:8];
  logic [8:0] exp_stall  [0:13];
  logic [6:0] exp_one    [0:5];

  initial begin
    exp_stream[0] = 9'b100000_000; exp_stream[1] = 9'b010000_000;
    exp_stream[2] = 9'b001100_000; exp_stream[3] = 9'b000110_001;
    exp_stream[4] = 9'b000110_010; exp_stream[5] = 9'b000110_011;
    exp_stream[6] = 9'b000110_100; exp_stream[7] = 9'b000001_000;
    exp_stream[8] = 9'b100000_000;

    exp_stall[0]  = 9'b100000_000; exp_stall[1]  = 9'b010000_000;
    exp_stall[2]  = 9'b001100_000; exp_stall[3]  = 9'b000110_001;
    exp_stall[4]  = 9'b000010_010; exp_stall[5]  = 9'b000010_010;
    exp_stall[6]  = 9'b000110_010; exp_stall[7]  = 9'b000110_011;
    exp_stall[8]  = 9'b000110_100; exp_stall[9]  = 9'b000001_000;
    exp_stall[10] = 9'b000001_000; exp_stall[11] = 9'b000001_000;
    exp_stall[12] = 9'b000001_000; exp_stall[13] = 9'b100000_000;

    exp_one[0] = 7'b100000_0; exp_one[1] = 7'b010000_0;
    exp_one[2] = 7'b001100_0; exp_one[3] = 7'b000110_1;
    exp_one[4] = 7'b000001_0; exp_one[5] = 7'b100000_0;

    // Reset held for two edges, clear visible throughout
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check_eq("rst_clear_c0", 32'(lu_clear_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check_eq("rst_clear_c1", 32'(lu_clear_o), 32'd1);
    @(posedge clk); #1;
    reset_i = 1'b0;
    cyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 9'b100000_000);
    check_eq("rst_idle_n1", 32'(obs1), 32'(7'b100000_0));

    // Streaming run
    for (int c = 0; c <= 8; c++)
      cyc($sformatf("stream_c%0d", c), 1'b0, c == 0, 1'b1, 1'b1, exp_stream[c]);
    check_eq("stream_acc", 32'(acc), 32'h0500);

    // Stall in cycles 4-5, then backpressure with an ignored start in DONE
    for (int c = 0; c <= 13; c++)
      cyc($sformatf("stall_c%0d", c), 1'b0, (c == 0) || (c == 10),
          !(c == 4 || c == 5), !(c >= 9 && c <= 11), exp_stall[c]);
    check_eq("stall_acc", 32'(acc), 32'h0500);

    // Reset mid-MAC discards the job
    for (int c = 0; c <= 3; c++)
      cyc($sformatf("rmac_c%0d", c), 1'b0, c == 0, 1'b1, 1'b1, exp_stream[c]);
    cyc("rmac_c4_rst", 1'b1, 1'b0, 1'b1, 1'b1, 9'b010010_010);
    for (int c = 5; c <= 8; c++)
      cyc($sformatf("rmac_c%0d", c), 1'b0, 1'b0, 1'b1, 1'b1, 9'b100000_000);
    for (int c = 0; c <= 8; c++)
      cyc($sformatf("rerun_c%0d", c), 1'b0, c == 0, 1'b1, 1'b1, exp_stream[c]);
    check_eq("rerun_acc", 32'(acc), 32'h0500);

    // Single-input neuron
    for (int c = 0; c <= 5; c++) begin
      start1_i = (c == 0);
      @(negedge clk);
      check_eq($sformatf("n1_c%0d", c), 32'(obs1), 32'(exp_one[c]));
      @(posedge clk); #1;
    end
    start1_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 8, meaning the number of weighted inputs per neuron (legal range >= 1).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N_INPUTS+1), meaning the width of the weight-memory address.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start_i, input, 1, request to begin one neuron computation.
REQ-006 SHALL have port ready_o, output, 1, sequencer idle and able to accept start_i.
REQ-007 SHALL have port data_valid_i, input, 1, upstream input sample present on the datapath data bus.
REQ-008 SHALL have port data_ready_o, output, 1, sequencer consuming input samples.
REQ-009 SHALL have port mem_addr_o, output, ADDR_WIDTH, weight-memory address; address 0 holds the bias and address k holds weight k.
REQ-010 SHALL have port lu_clear_o, output, 1, clears the datapath accumulator.
REQ-011 SHALL have port lu_add_bias_o, output, 1, datapath adds the memory word instead of the product.
REQ-012 SHALL have port lu_sum_en_o, output, 1, datapath accumulate enable.
REQ-013 SHALL have port valid_o, output, 1, datapath output holds the finished neuron sum.
REQ-014 SHALL have port ready_i, input, 1, downstream accepts the result.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, BIAS, MAC and DONE, with an input counter cnt of ADDR_WIDTH bits.
REQ-016 In IDLE: ready_o=1 and all other outputs 0; start_i=1 moves to CLEAR.
REQ-017 In CLEAR (one cycle): lu_clear_o=1 and cnt<=0; always moves to BIAS.
REQ-018 In BIAS (one cycle): mem_addr_o=0, lu_add_bias_o=1 and lu_sum_en_o=1; always moves to MAC.
REQ-019 In MAC: data_ready_o=1, mem_addr_o=cnt+1 and lu_sum_en_o=data_valid_i.
REQ-020 In MAC, when data_valid_i=1 and cnt<N_INPUTS-1: cnt increments.
REQ-021 In MAC, when data_valid_i=1 and cnt==N_INPUTS-1: moves to DONE.
REQ-022 In MAC, when data_valid_i=0 (stall): cnt and mem_addr_o are held and there is no accumulate.
REQ-023 In DONE: valid_o=1 and lu_sum_en_o=0; ready_i=1 moves to IDLE; otherwise the sequencer holds DONE and valid_o indefinitely.
REQ-024 start_i SHALL be ignored in every state except IDLE; there is no queuing.
REQ-025 Back-to-back jobs SHALL be separated by at least one IDLE cycle (ready_o is asserted only in IDLE).
REQ-026 Latency with no stalls SHALL be fixed:
- start accepted in cycle 0;
- CLEAR in cycle 1 and BIAS in cycle 2;
- MAC in cycles 3..N_INPUTS+2;
- valid_o first high in cycle N_INPUTS+3.
Each stall cycle SHALL add exactly one cycle of latency.
REQ-027 lu_add_bias_o and data_ready_o SHALL never be high in the same cycle.
REQ-028 lu_clear_o and lu_sum_en_o SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be decoded from the registered state and cnt only, except lu_sum_en_o in MAC (REQ-019) and lu_clear_o during reset (REQ-032); there are no other combinational input-to-output paths.
REQ-030 With N_INPUTS=1, MAC SHALL last exactly one accepted sample (address 1) before DONE.

Reset
REQ-031 While reset_i=1 at a clock edge, the state SHALL become IDLE and cnt SHALL become 0, in any state, including mid-MAC and in DONE.
REQ-032 lu_clear_o SHALL be 1 in any cycle where reset_i=1.
REQ-033 After the reset edge: ready_o=1; valid_o, data_ready_o, lu_add_bias_o and lu_sum_en_o are 0; mem_addr_o=0.
REQ-034 Any partially accumulated result SHALL be discarded and valid_o SHALL NOT assert for an interrupted job.

Verification
REQ-035 Reset then idle: hold reset_i 2 cycles, release -> ready_o=1, valid_o=0, mem_addr_o=0, lu_clear_o=1 only during reset cycles.
REQ-036 Streaming run, N_INPUTS=4, data_valid_i=1 continuously, start_i in cycle 0:
- lu_clear_o=1 in cycle 1;
- mem_addr_o = 0,1,2,3,4 in cycles 2..6, with lu_sum_en_o=1 throughout and lu_add_bias_o=1 only in cycle 2;
- valid_o=1 from cycle 7.
With bias 1.0, weights 0.5 and inputs 2.0 (Q8.8), the datapath output SHALL be 5.0 (0x0500).
REQ-037 Stall: same run with data_valid_i=0 in cycles 4-5 -> mem_addr_o holds 2 and lu_sum_en_o=0 during the stall; valid_o first high in cycle 9; accumulated value unchanged.
REQ-038 Backpressure: ready_i=0 for 3 cycles after valid_o -> valid_o held steady; ready_i=1 -> IDLE next cycle, ready_o=1; start_i asserted during DONE is ignored.
REQ-039 Reset mid-MAC: reset_i=1 in cycle 4 -> IDLE in cycle 5, lu_clear_o=1 in cycle 4, no valid_o afterward; a new start_i then completes normally per REQ-026.
REQ-040 N_INPUTS=1: start in cycle 0 -> BIAS in cycle 2, mem_addr_o=1 in cycle 3, valid_o in cycle 4.
